// File: rtl/rv32i_mem_bridge.sv
// -----------------------------------------------------------------------------
// rv32i_mem_bridge
//
// Data-side memory bridge sitting directly behind the rv32i multicycle core's
// memory port. Handles one load/store at a time, tagged with the RV32I funct3.
//   * RAM accesses are word-only against a synchronous RAM with RAM_LATENCY
//     cycles of read latency. Sub-word loads are extracted and sign/zero
//     extended here; sub-word stores are done as read-modify-write.
//   * A 64 KiB MMIO window at MMIO_BASE is forwarded to a combinational slave
//     with byte enables (no read-modify-write on that side).
//   * ready is meant to drive the core's ena, stalling it while busy.
//
// Compile-time option:
//   MEM_BRIDGE_MISALIGN_TRAP_EN
//     defined   : misaligned LH/LHU/SH/LW/SW return rsp_err with no side effects.
//     undefined : low address bits are forced to natural alignment and the
//                 access proceeds.
//
// Ports
//   clk, rst         clock (rising edge) / asynchronous active-low reset
//   req_valid        request present; accepted when ready is high
//   req_we           1 = store, 0 = load
//   req_funct3       RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr         byte address
//   req_wdata        right-justified store data
//   ready            high only in IDLE
//   rsp_valid        one-cycle completion pulse
//   rsp_rdata        extended load data, held until the next accept
//   rsp_err          error flag, meaningful with rsp_valid
//   ram_addr         RAM word index
//   ram_wr_data      full word to write
//   ram_wr_ena       RAM write strobe
//   ram_rd_data      RAM read data, RAM_LATENCY cycles after ram_addr
//   mmio_addr        word-aligned byte offset inside the MMIO window
//   mmio_wr_data     lane-positioned store data
//   mmio_be          little-endian byte enables
//   mmio_wr_ena      one-cycle MMIO write strobe
//   mmio_rd_ena      one-cycle MMIO read strobe, mmio_rd_data sampled same cycle
//   mmio_rd_data     MMIO read data
// -----------------------------------------------------------------------------
module rv32i_mem_bridge #(
  parameter int unsigned RAM_DEPTH   = 1024,
  parameter int unsigned RAM_LATENCY = 1,            // legal 1..4
  parameter logic [31:0] MMIO_BASE   = 32'hF000_0000,
  localparam int unsigned RAM_AW     = $clog2(RAM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wr_data,
  output logic              ram_wr_ena,
  input  logic [31:0]       ram_rd_data,
  output logic [15:0]       mmio_addr,
  output logic [31:0]       mmio_wr_data,
  output logic [3:0]        mmio_be,
  output logic              mmio_wr_ena,
  output logic              mmio_rd_ena,
  input  logic [31:0]       mmio_rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_MMIO,
    ST_RESP
  } state_e;

  // Everything about the accepted request that later states need.
  typedef struct packed {
    logic        we;
    logic        mmio;
    logic        err;
    logic        uns;    // funct3[2]: zero-extend loads
    logic [1:0]  size;   // 0 byte, 1 half, 2 word
    logic [1:0]  lane;   // aligned addr[1:0]
    logic [31:0] wdata;
  } req_t;

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] lane_be(input logic [1:0] size,
                                         input logic [1:0] lane);
    case (size)
      2'd0:    lane_be = 4'b0001 << lane;
      2'd1:    lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Places the right-justified store data into its lanes on top of old_word.
  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] wdata,
                                        input logic [1:0]  size,
                                        input logic [1:0]  lane);
    logic [3:0]  be;
    logic [31:0] mask;
    logic [31:0] repl;
    be   = lane_be(size, lane);
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    case (size)
      2'd0:    repl = {4{wdata[7:0]}};
      2'd1:    repl = {2{wdata[15:0]}};
      default: repl = wdata;
    endcase
    merge = (old_word & ~mask) | (repl & mask);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane,
                                          input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode (only consumed in IDLE)
  // ---------------------------------------------------------------------------
  logic [1:0]  in_size;
  logic        f3_bad;
  logic        misalign;
  logic [31:0] addr_al;
  logic [31:0] mmio_off;
  logic        in_mmio;
  logic        out_of_range;
  logic        dec_err;

  always_comb begin
    in_size = req_funct3[1:0];
    if (req_we) f3_bad = (req_funct3 > 3'd2);
    else        f3_bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                         (req_funct3 == 3'd7);
`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
    misalign = ((in_size == 2'd1) && req_addr[0]) ||
               ((in_size == 2'd2) && (req_addr[1:0] != 2'b00));
    addr_al  = req_addr;
`else
    misalign = 1'b0;
    case (in_size)
      2'd1:    addr_al = {req_addr[31:1], 1'b0};
      2'd2:    addr_al = {req_addr[31:2], 2'b00};
      default: addr_al = req_addr;
    endcase
`endif
    // Subtract-and-test keeps the window check correct for any MMIO_BASE.
    mmio_off     = addr_al - MMIO_BASE;
    in_mmio      = (mmio_off[31:16] == 16'd0);
    out_of_range = ({2'b00, addr_al[31:2]} >= 32'(RAM_DEPTH));
    dec_err      = f3_bad || misalign || (!in_mmio && out_of_range);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  req_t              req_q,       req_d;
  logic [2:0]        cnt_q,       cnt_d;
  logic [RAM_AW-1:0] ram_addr_q,  ram_addr_d;
  logic [15:0]       mmio_addr_q, mmio_addr_d;
  logic [31:0]       mmio_wd_q,   mmio_wd_d;
  logic [3:0]        mmio_be_q,   mmio_be_d;
  logic [31:0]       rdata_q,     rdata_d;

  // RAM load data arrives during RESP, so it is forwarded combinationally in
  // that cycle and captured into rdata_q for the hold afterwards.
  logic ram_load_resp;
  assign ram_load_resp = (state_q == ST_RESP) && !req_q.we && !req_q.err &&
                         !req_q.mmio;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    mmio_addr_d = mmio_addr_q;
    mmio_wd_d   = mmio_wd_q;
    mmio_be_d   = mmio_be_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.mmio  = in_mmio;
          req_d.err   = dec_err;
          req_d.uns   = req_funct3[2];
          req_d.size  = in_size;
          req_d.lane  = addr_al[1:0];
          req_d.wdata = req_wdata;
          cnt_d       = 3'd0;
          rdata_d     = 32'd0;
          if (dec_err) begin
            state_d = ST_RESP;
          end else if (in_mmio) begin
            state_d     = ST_MMIO;
            mmio_addr_d = mmio_off[15:0] & 16'hFFFC;
            mmio_be_d   = lane_be(in_size, addr_al[1:0]);
            mmio_wd_d   = req_we ? merge(32'd0, req_wdata, in_size, addr_al[1:0])
                                 : 32'd0;
          end else begin
            ram_addr_d = addr_al[RAM_AW+1:2];
            // Only full-word stores skip the read half of read-modify-write.
            state_d    = (req_we && (in_size == 2'd2)) ? ST_WRITE : ST_READ;
          end
        end
      end

      ST_READ: begin
        if (cnt_q == 3'(RAM_LATENCY - 1)) state_d = req_q.we ? ST_WRITE : ST_RESP;
        else                              cnt_d   = cnt_q + 3'd1;
      end

      ST_WRITE: state_d = ST_RESP;

      ST_MMIO: begin
        if (!req_q.we)
          rdata_d = extract(mmio_rd_data, req_q.size, req_q.lane, req_q.uns);
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (ram_load_resp)
          rdata_d = extract(ram_rd_data, req_q.size, req_q.lane, req_q.uns);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= 3'd0;
      ram_addr_q  <= '0;
      mmio_addr_q <= 16'd0;
      mmio_wd_q   <= 32'd0;
      mmio_be_q   <= 4'd0;
      rdata_q     <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      mmio_addr_q <= mmio_addr_d;
      mmio_wd_q   <= mmio_wd_d;
      mmio_be_q   <= mmio_be_d;
      rdata_q     <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes decode straight from state_q so an asynchronous reset
  // drops them in the same instant.
  // ---------------------------------------------------------------------------
  assign ready        = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_err      = rsp_valid && req_q.err;
  assign rsp_rdata    = ram_load_resp
                        ? extract(ram_rd_data, req_q.size, req_q.lane, req_q.uns)
                        : rdata_q;

  assign ram_addr     = ram_addr_q;
  assign ram_wr_ena   = (state_q == ST_WRITE);
  // For SB/SH the read word is on ram_rd_data during WRITE.
  assign ram_wr_data  = ram_wr_ena
                        ? merge(ram_rd_data, req_q.wdata, req_q.size, req_q.lane)
                        : 32'd0;

  assign mmio_addr    = mmio_addr_q;
  assign mmio_wr_data = mmio_wd_q;
  assign mmio_be      = mmio_be_q;
  assign mmio_wr_ena  = (state_q == ST_MMIO) && req_q.we;
  assign mmio_rd_ena  = (state_q == ST_MMIO) && !req_q.we;

endmodule
